// File: rtl/seq_det_scheduler.sv
// seq_det_scheduler
//   Round-robin scheduler sharing one bit-serial Moore "101" detector among
//   NREQ requesters. The granted word is shifted MSB-first through the
//   detector, one bit per clock, and the overlapping match count is reported
//   together with the requester index.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   req        per-requester request level (sampled only in IDLE)
//   data       requester i's word is data[i*WIDTH +: WIDTH]
//   gnt        one-hot, single-cycle grant pulse (cycle after the grant edge)
//   busy       high whenever the controller is not IDLE
//   done       single-cycle result-valid pulse (REPORT cycle)
//   done_id    index of the requester whose word finished
//   match_cnt  number of "101" matches in the finished word
module seq_det_scheduler #(
   parameter int NREQ  = 2,
   parameter int WIDTH = 8,
   parameter int IDW   = $clog2(NREQ),
   parameter int CW    = $clog2(WIDTH)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ*WIDTH-1:0]   data,
   output logic [NREQ-1:0]         gnt,
   output logic                    busy,
   output logic                    done,
   output logic [IDW-1:0]          done_id,
   output logic [CW-1:0]           match_cnt
);

   localparam int          BW = $clog2(WIDTH);
   localparam int unsigned NR = NREQ;

   typedef enum logic [1:0] {IDLE, SHIFT, REPORT} state_t;
   typedef enum logic [1:0] {S0, S1, S10, S101} det_t;

   state_t            state, state_nxt;
   det_t              det, det_nxt;
   logic [WIDTH-1:0]  shreg;
   logic [WIDTH-1:0]  win_data;
   logic [BW-1:0]     bitcnt;
   logic [IDW-1:0]    last_id;
   logic [IDW-1:0]    win_id;
   logic              any_req;
   logic              last_bit;
   logic              found;
   int unsigned       idx;

   assign any_req  = |req;
   assign last_bit = (bitcnt == BW'(WIDTH-1));
   assign busy     = (state != IDLE);
   assign done     = (state == REPORT);

   // Controller state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Controller next-state logic
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (any_req)  state_nxt = SHIFT;
         SHIFT:   if (last_bit) state_nxt = REPORT;
         REPORT:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Round-robin pick: scan from last_id+1 upward, wrapping once.
   always_comb begin
      win_id = last_id;
      found  = 1'b0;
      idx    = 0;
      for (int unsigned k = 0; k < NR; k++) begin
         idx = 32'(last_id) + 32'd1 + k;
         if (idx >= NR) idx = idx - NR;
         if (!found && req[idx]) begin
            found  = 1'b1;
            win_id = IDW'(idx);
         end
      end
   end

   always_comb begin
      win_data = '0;
      for (int unsigned i = 0; i < NR; i++) begin
         if (win_id == IDW'(i)) win_data = data[i*WIDTH +: WIDTH];
      end
   end

   // Detector next state for the bit currently at the MSB of the shift register
   always_comb begin
      det_nxt = det;
      unique case (det)
         S0:      det_nxt = shreg[WIDTH-1] ? S1   : S0;
         S1:      det_nxt = shreg[WIDTH-1] ? S1   : S10;
         S10:     det_nxt = shreg[WIDTH-1] ? S101 : S0;
         S101:    det_nxt = shreg[WIDTH-1] ? S1   : S10;
         default: det_nxt = S0;
      endcase
   end

   // Datapath: grant capture, shifting, detector state and match counting.
   // match_cnt is the live counter; it is cleared only at a grant, so it
   // holds the finished word's count from REPORT until the next grant.
   always_ff @(posedge clk) begin
      if (rst) begin
         gnt       <= '0;
         shreg     <= '0;
         bitcnt    <= '0;
         match_cnt <= '0;
         done_id   <= '0;
         last_id   <= IDW'(NREQ-1);
         det       <= S0;
      end else begin
         gnt <= '0;
         unique case (state)
            IDLE: begin
               if (any_req) begin
                  gnt       <= NREQ'(1) << win_id;
                  shreg     <= win_data;
                  bitcnt    <= '0;
                  match_cnt <= '0;
                  det       <= S0;
                  done_id   <= win_id;
                  last_id   <= win_id;
               end
            end
            SHIFT: begin
               det    <= det_nxt;
               shreg  <= {shreg[WIDTH-2:0], 1'b0};
               bitcnt <= bitcnt + BW'(1);
               if (det_nxt == S101) match_cnt <= match_cnt + CW'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_det_scheduler.sv
// Directed self-checking bench for seq_det_scheduler (NREQ=2, WIDTH=8).
module tb_seq_det_scheduler;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req;
   logic [15:0] data;
   logic [1:0]  gnt;
   logic        busy;
   logic        done;
   logic [0:0]  done_id;
   logic [2:0]  match_cnt;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   seq_det_scheduler #(.NREQ(2), .WIDTH(8)) dut (
      .clk(clk), .rst(rst), .req(req), .data(data), .gnt(gnt),
      .busy(busy), .done(done), .done_id(done_id), .match_cnt(match_cnt)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issues one word from requester id and observes grant, latency from the
   // grant edge to done (in edges), result, busy one cycle after REPORT and
   // any grant pulse seen while the word was in flight.
   task automatic run_word(input int id, input logic [7:0] w,
                           output logic [1:0] g, output int lat,
                           output logic [2:0] cnt, output logic [0:0] did,
                           output logic bz, output int extra);
      data[id*8 +: 8] = w;
      req = 2'(1 << id);
      tick();
      g   = gnt;
      req = '0;
      lat = -1; cnt = '0; did = '0; extra = 0;
      for (int c = 1; c <= 20; c++) begin
         tick();
         if (gnt !== 2'b00) extra++;
         if (done === 1'b1) begin
            lat = c; cnt = match_cnt; did = done_id;
            break;
         end
      end
      tick();
      bz = busy;
   endtask

   task automatic test_reset();
      rst = 1'b1; req = '0; data = '0;
      tick(); tick();
      tests++; if (gnt !== 2'b00)     begin fails++; $display("FAIL reset_gnt: got %b expected 00", gnt); end
      tests++; if (busy !== 1'b0)     begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
      tests++; if (done !== 1'b0)     begin fails++; $display("FAIL reset_done: got %b expected 0", done); end
      tests++; if (done_id !== 1'b0)  begin fails++; $display("FAIL reset_done_id: got %0d expected 0", done_id); end
      tests++; if (match_cnt !== 3'd0) begin fails++; $display("FAIL reset_match_cnt: got %0d expected 0", match_cnt); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_single();
      logic [1:0] g; int lat; logic [2:0] cnt; logic [0:0] did; logic bz; int extra;
      run_word(0, 8'b10101010, g, lat, cnt, did, bz, extra);
      tests++; if (g !== 2'b01)   begin fails++; $display("FAIL single_gnt: got %b expected 01", g); end
      tests++; if (lat != 8)      begin fails++; $display("FAIL single_latency: got %0d expected 8", lat); end
      tests++; if (cnt !== 3'd3)  begin fails++; $display("FAIL single_cnt: got %0d expected 3", cnt); end
      tests++; if (did !== 1'b0)  begin fails++; $display("FAIL single_id: got %0d expected 0", did); end
      tests++; if (bz !== 1'b0)   begin fails++; $display("FAIL single_busy_after: got %b expected 0", bz); end
      tests++; if (extra != 0)    begin fails++; $display("FAIL single_extra_gnt: got %0d expected 0", extra); end
   endtask

   task automatic test_overlap();
      logic [1:0] g; int lat; logic [2:0] cnt; logic [0:0] did; logic bz; int extra;
      run_word(1, 8'b11011011, g, lat, cnt, did, bz, extra);
      tests++; if (g !== 2'b10)   begin fails++; $display("FAIL overlap_gnt: got %b expected 10", g); end
      tests++; if (cnt !== 3'd2)  begin fails++; $display("FAIL overlap_cnt: got %0d expected 2", cnt); end
      tests++; if (did !== 1'b1)  begin fails++; $display("FAIL overlap_id: got %0d expected 1", did); end
      run_word(0, 8'b00000000, g, lat, cnt, did, bz, extra);
      tests++; if (lat != 8)      begin fails++; $display("FAIL zero_done_latency: got %0d expected 8", lat); end
      tests++; if (cnt !== 3'd0)  begin fails++; $display("FAIL zero_cnt: got %0d expected 0", cnt); end
   endtask

   task automatic test_cross_word();
      logic [1:0] g; int lat; logic [2:0] cnt; logic [0:0] did; logic bz; int extra;
      run_word(0, 8'b00000010, g, lat, cnt, did, bz, extra);
      tests++; if (cnt !== 3'd0)  begin fails++; $display("FAIL cross_first_cnt: got %0d expected 0", cnt); end
      run_word(0, 8'b10000000, g, lat, cnt, did, bz, extra);
      tests++; if (lat != 8)      begin fails++; $display("FAIL cross_second_latency: got %0d expected 8", lat); end
      tests++; if (cnt !== 3'd0)  begin fails++; $display("FAIL cross_second_cnt: got %0d expected 0", cnt); end
   endtask

   task automatic test_round_robin();
      logic [1:0] gs [4];
      int         dt [4];
      logic [0:0] ids[4];
      logic [2:0] cs [4];
      logic [1:0] eg [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
      logic [0:0] ei [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
      logic [2:0] ec [4] = '{3'd3, 3'd2, 3'd3, 3'd2};
      int ng = 0, nd = 0, cyc = 0;
      for (int i = 0; i < 4; i++) begin gs[i] = 'x; dt[i] = -100; ids[i] = 'x; cs[i] = 'x; end
      data = {8'b11011011, 8'b10101010};
      rst = 1'b1; req = 2'b11;
      tick();
      tests++; if (gnt !== 2'b00) begin fails++; $display("FAIL rst_vs_req_gnt: got %b expected 00", gnt); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_vs_req_busy: got %b expected 0", busy); end
      rst = 1'b0;
      for (int k = 0; k < 80 && nd < 4; k++) begin
         tick(); cyc++;
         if (gnt !== 2'b00 && ng < 4) begin gs[ng] = gnt; ng++; end
         if (done === 1'b1) begin
            dt[nd] = cyc; ids[nd] = done_id; cs[nd] = match_cnt; nd++;
            if (nd == 4) req = '0;
         end
      end
      tests++; if (nd != 4) begin fails++; $display("FAIL rr_done_count: got %0d expected 4", nd); end
      for (int i = 0; i < 4; i++) begin
         tests++; if (gs[i] !== eg[i])  begin fails++; $display("FAIL rr_gnt%0d: got %b expected %b", i, gs[i], eg[i]); end
         tests++; if (ids[i] !== ei[i]) begin fails++; $display("FAIL rr_id%0d: got %0d expected %0d", i, ids[i], ei[i]); end
         tests++; if (cs[i] !== ec[i])  begin fails++; $display("FAIL rr_cnt%0d: got %0d expected %0d", i, cs[i], ec[i]); end
      end
      for (int i = 1; i < 4; i++) begin
         tests++; if (dt[i] - dt[i-1] != 10) begin fails++; $display("FAIL rr_period%0d: got %0d expected 10", i, dt[i] - dt[i-1]); end
      end
      for (int k = 0; k < 20 && busy === 1'b1; k++) tick();
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rr_drain_busy: got %b expected 0", busy); end
   endtask

   task automatic test_req_stability();
      int lat = -1, extra = 0;
      logic [2:0] cnt = '0;
      data = {8'h00, 8'b10101010};
      req = 2'b01;
      tick();
      tests++; if (gnt !== 2'b01) begin fails++; $display("FAIL stab_gnt: got %b expected 01", gnt); end
      for (int c = 1; c <= 20; c++) begin
         tick();
         if (gnt !== 2'b00) extra++;
         if (done === 1'b1) begin lat = c; cnt = match_cnt; break; end
         if (c == 2) begin req = 2'b10; data = 16'hFFFF; end
      end
      tests++; if (lat != 8)     begin fails++; $display("FAIL stab_latency: got %0d expected 8", lat); end
      tests++; if (cnt !== 3'd3) begin fails++; $display("FAIL stab_cnt: got %0d expected 3", cnt); end
      tests++; if (extra != 0)   begin fails++; $display("FAIL stab_extra_gnt: got %0d expected 0", extra); end
      tick();
      tests++; if (gnt !== 2'b00) begin fails++; $display("FAIL stab_report_ignores_req: got %b expected 00", gnt); end
      tick();
      tests++; if (gnt !== 2'b10) begin fails++; $display("FAIL stab_next_gnt: got %b expected 10", gnt); end
      req = '0;
      for (int k = 0; k < 20 && busy === 1'b1; k++) tick();
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL stab_drain_busy: got %b expected 0", busy); end
   endtask

   task automatic test_reset_mid_shift();
      int ndone = 0, lat = -1;
      data = {8'h00, 8'b10101010};
      req = 2'b01;
      tick();
      req = '0;
      tick(); tick(); tick();
      tests++; if (match_cnt !== 3'd1) begin fails++; $display("FAIL mid_precount: got %0d expected 1", match_cnt); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tests++; if (gnt !== 2'b00)      begin fails++; $display("FAIL mid_rst_gnt: got %b expected 00", gnt); end
      tests++; if (busy !== 1'b0)      begin fails++; $display("FAIL mid_rst_busy: got %b expected 0", busy); end
      tests++; if (done !== 1'b0)      begin fails++; $display("FAIL mid_rst_done: got %b expected 0", done); end
      tests++; if (done_id !== 1'b0)   begin fails++; $display("FAIL mid_rst_done_id: got %0d expected 0", done_id); end
      tests++; if (match_cnt !== 3'd0) begin fails++; $display("FAIL mid_rst_match_cnt: got %0d expected 0", match_cnt); end
      for (int k = 0; k < 12; k++) begin
         tick();
         if (done === 1'b1) ndone++;
      end
      tests++; if (ndone != 0) begin fails++; $display("FAIL mid_dropped_done: got %0d expected 0", ndone); end
      req = 2'b11;
      tick();
      tests++; if (gnt !== 2'b01) begin fails++; $display("FAIL mid_pointer_reset_gnt: got %b expected 01", gnt); end
      req = '0;
      for (int c = 1; c <= 20; c++) begin
         tick();
         if (done === 1'b1) begin lat = c; break; end
      end
      tests++; if (lat != 8) begin fails++; $display("FAIL mid_after_latency: got %0d expected 8", lat); end
      tick();
   endtask

   initial begin
      rst = 1'b1; req = '0; data = '0;
      test_reset();
      test_single();
      test_overlap();
      test_cross_word();
      test_round_robin();
      test_req_stability();
      test_reset_mid_shift();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
